ff_sync_filt: RTL and testbench

Multi-channel, parametrised synchroniser for asynchronous level inputs (straps, status lines, handshake levels) entering a clock domain. Each channel has a configurable-depth flip-flop chain, a per-channel stability (deglitch) filter, and registered rise/fall edge pulses. It generalises the two-stage synchroniser with variable stage count, a programmable reset value, glitch rejection and edge detection.

---
 rtl/ff_sync_filt.sv | 118 +++++++++++
 tb/tb_ff_sync_filt.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ff_sync_filt.sv
// ff_sync_filt: multi-channel synchroniser for asynchronous level inputs.
// Each channel passes through a STAGES-deep flip-flop chain, then a
// stability filter that only lets a new level through once it has been
// seen for FILT_LEN consecutive synchronised cycles. Rise/fall pulses are
// registered alongside the filtered level.
//
// Ports:
//   clk      in   1      single clock, rising edge
//   rst      in   1      synchronous reset, active low
//   din      in   WIDTH  asynchronous level inputs
//   dq       out  WIDTH  synchronised, filtered levels
//   rise     out  WIDTH  one-cycle pulse when dq goes 0->1
//   fall     out  WIDTH  one-cycle pulse when dq goes 1->0
//   changed  out  1      OR of all rise/fall bits, same cycle
module ff_sync_filt #(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      STAGES   = 2,
    parameter int unsigned      FILT_LEN = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dq,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned     CW       = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_LEN - 1);

    generate
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("ff_sync_filt: STAGES must be in 2..8");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("ff_sync_filt: WIDTH must be in 1..64");
        end
        if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt
            $error("ff_sync_filt: FILT_LEN must be in 1..255");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s_out;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    // Plain flop chain: nothing may sit between stages or the
    // metastability settling time is eaten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_out = sync_q[STAGES-1];

    // Counter runs only while the synchronised value disagrees with dq;
    // any agreement clears it, so short pulses never accumulate.
    always_comb begin
        dq_d = dq_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s_out[i] != dq_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    dq_d[i] = s_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise_d    = dq_d & ~dq_q;
        fall_d    = ~dq_d & dq_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dq_q      <= RST_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dq_q      <= dq_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dq      = dq_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_ff_sync_filt.sv
// Directed bench for ff_sync_filt using three instances:
//   u_a  STAGES=2 FILT_LEN=1 RST_VAL=0   latency, simultaneous edges
//   u_b  STAGES=3 FILT_LEN=4 RST_VAL=0   glitch rejection, independence
//   u_c  STAGES=2 FILT_LEN=8 RST_VAL=8   reset in the middle of a filter
module tb_ff_sync_filt;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] din_a, din_b, din_c;
    logic [3:0] dq_a, rise_a, fall_a;
    logic [3:0] dq_b, rise_b, fall_b;
    logic [3:0] dq_c, rise_c, fall_c;
    logic       chg_a, chg_b, chg_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ff_sync_filt #(.WIDTH(4), .STAGES(2), .FILT_LEN(1), .RST_VAL(4'h0)) u_a (
        .clk(clk), .rst(rst_a), .din(din_a),
        .dq(dq_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));

    ff_sync_filt #(.WIDTH(4), .STAGES(3), .FILT_LEN(4), .RST_VAL(4'h0)) u_b (
        .clk(clk), .rst(rst_b), .din(din_b),
        .dq(dq_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));

    ff_sync_filt #(.WIDTH(4), .STAGES(2), .FILT_LEN(8), .RST_VAL(4'h8)) u_c (
        .clk(clk), .rst(rst_c), .din(din_c),
        .dq(dq_c), .rise(rise_c), .fall(fall_c), .changed(chg_c));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        din_a = 4'hF; din_b = 4'hF; din_c = 4'hF;

        // 1. reset holds everything at RST_VAL with no pulses
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_dq_a",  16'(dq_a), 16'h0);
            chk("rst_pul_a", 16'({rise_a, fall_a, chg_a}), 16'h0);
            chk("rst_dq_c",  16'(dq_c), 16'h8);
            chk("rst_pul_c", 16'({rise_c, fall_c, chg_c}), 16'h0);
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        din_a = 4'h0; din_b = 4'h0; din_c = 4'h8;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rel_dq_a",  16'(dq_a), 16'h0);
            chk("rel_pul_a", 16'({rise_a, fall_a, chg_a}), 16'h0);
            chk("rel_pul_b", 16'({rise_b, fall_b, chg_b}), 16'h0);
            chk("rel_dq_c",  16'(dq_c), 16'h8);
            chk("rel_pul_c", 16'({rise_c, fall_c, chg_c}), 16'h0);
        end

        // 2. latency STAGES+1 = 3 edges
        din_a = 4'h5;
        step(); chk("lat_e1", 16'(dq_a), 16'h0);
        step(); chk("lat_e2", 16'(dq_a), 16'h0);
                chk("lat_e2_pul", 16'({rise_a, fall_a, chg_a}), 16'h0);
        step(); chk("lat_e3", 16'(dq_a), 16'h5);
                chk("lat_e3_rise", 16'(rise_a), 16'h5);
                chk("lat_e3_fall", 16'(fall_a), 16'h0);
                chk("lat_e3_chg",  16'(chg_a), 16'h1);
        step(); chk("lat_e4", 16'(dq_a), 16'h5);
                chk("lat_e4_pul", 16'({rise_a, fall_a, chg_a}), 16'h0);

        // 4. simultaneous rise and fall on different channels
        din_a = 4'h2;
        step(); step(); step();
        chk("sim_pre_dq",   16'(dq_a), 16'h2);
        chk("sim_pre_rise", 16'(rise_a), 16'h2);
        chk("sim_pre_fall", 16'(fall_a), 16'h5);
        step();
        din_a = 4'h1;
        step(); chk("sim_e1", 16'(dq_a), 16'h2);
        step(); chk("sim_e2", 16'(dq_a), 16'h2);
        step(); chk("sim_e3_dq",   16'(dq_a), 16'h1);
                chk("sim_e3_rise", 16'(rise_a), 16'h1);
                chk("sim_e3_fall", 16'(fall_a), 16'h2);
                chk("sim_e3_chg",  16'(chg_a), 16'h1);
        step(); chk("sim_e4_pul", 16'({rise_a, fall_a, chg_a}), 16'h0);

        // 3. glitch rejection, STAGES=3 FILT_LEN=4
        din_b = 4'h1;
        step(); step(); step();
        din_b = 4'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("gl_dq",  16'(dq_b), 16'h0);
            chk("gl_pul", 16'({rise_b, fall_b, chg_b}), 16'h0);
        end
        din_b = 4'h1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("hold_dq", 16'(dq_b), 16'h0);
        end
        step(); chk("hold_e7_dq",   16'(dq_b), 16'h1);
                chk("hold_e7_rise", 16'(rise_b), 16'h1);
                chk("hold_e7_chg",  16'(chg_b), 16'h1);
        step(); chk("hold_e8_pul",  16'({rise_b, fall_b, chg_b}), 16'h0);

        // 6. ch2 toggling every cycle, ch3 steps high
        din_b = 4'b1101;
        for (int i = 1; i <= 6; i++) begin
            step();
            din_b[2] = ~din_b[2];
            chk("ind_dq",  16'(dq_b), 16'h1);
            chk("ind_pul", 16'({rise_b, fall_b, chg_b}), 16'h0);
        end
        step();
        din_b[2] = ~din_b[2];
        chk("ind_e7_dq",   16'(dq_b), 16'h9);
        chk("ind_e7_rise", 16'(rise_b), 16'h8);
        chk("ind_e7_fall", 16'(fall_b), 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            din_b[2] = ~din_b[2];
            chk("ind_post_dq",  16'(dq_b), 16'h9);
            chk("ind_post_pul", 16'({rise_b, fall_b, chg_b}), 16'h0);
        end

        // 5. reset while cnt[1]=6, FILT_LEN=8
        din_c = 4'hA;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("mf_dq", 16'(dq_c), 16'h8);
        end
        rst_c = 1'b0;
        step();
        chk("mf_rst_dq",  16'(dq_c), 16'h8);
        chk("mf_rst_pul", 16'({rise_c, fall_c, chg_c}), 16'h0);
        rst_c = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("mf_relat_dq",  16'(dq_c), 16'h8);
            chk("mf_relat_pul", 16'({rise_c, fall_c, chg_c}), 16'h0);
        end
        step();
        chk("mf_e10_dq",   16'(dq_c), 16'hA);
        chk("mf_e10_rise", 16'(rise_c), 16'h2);
        chk("mf_e10_fall", 16'(fall_c), 16'h0);
        chk("mf_e10_chg",  16'(chg_c), 16'h1);
        step();
        chk("mf_e11_pul", 16'({rise_c, fall_c, chg_c}), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
